// File: rtl/imm_gen_stage_pkg.sv
// Shared types for the immediate-generation stage: immediate-type codes and the
// pipeline entry format held in the output and skid registers.
package imm_pkg;

  // Entry storage is sized for the widest supported configuration; narrower
  // instances leave the upper bits at zero and synthesis trims them.
  localparam int IMM_MAX_W = 64;
  localparam int TAG_MAX_W = 16;

  typedef enum logic [2:0] {
    IMM_I   = 3'd0,
    IMM_Z   = 3'd1,
    IMM_S   = 3'd2,
    IMM_B   = 3'd3,
    IMM_U   = 3'd4,
    IMM_J   = 3'd5,
    IMM_SH  = 3'd6,
    IMM_RSV = 3'd7
  } imm_type_e;

  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    logic [TAG_MAX_W-1:0] tag;
    logic                 illegal;
  } entry_t;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Decode-side request and execute-side response channels of the immediate stage.
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [2:0]       in_imm_type;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  // master: the decode/execute neighbours; slave: the stage itself
  modport master (
    output in_valid, in_inst, in_imm_type, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_imm_type, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational RISC-V immediate extraction; every format is first built as a
// 32-bit value and then widened, so one code path serves XLEN 32 and 64.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  input  imm_type_e       imm_type_i,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zx6(input logic [5:0] v);
    logic [XLEN-1:0] r;
    r      = '0;
    r[5:0] = v;
    return r;
  endfunction

  logic       s;
  logic [5:0] shamt;
  logic       unused_opc;

  assign s          = inst_i[31];
  assign shamt      = (XLEN == 64) ? inst_i[25:20] : {1'b0, inst_i[24:20]};
  // opcode bits never contribute to any immediate
  assign unused_opc = ^inst_i[6:0];

  always_comb begin
    imm_o     = '0;
    illegal_o = 1'b0;
    case (imm_type_i)
      IMM_I:   imm_o = sx32({{20{s}}, inst_i[31:20]});
      IMM_Z:   imm_o = zx6({1'b0, inst_i[19:15]});
      IMM_S:   imm_o = sx32({{20{s}}, inst_i[31:25], inst_i[11:7]});
      IMM_B:   imm_o = sx32({{19{s}}, s, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0});
      IMM_U:   imm_o = sx32({inst_i[31:12], 12'h000});
      IMM_J:   imm_o = sx32({{11{s}}, s, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0});
      IMM_SH:  imm_o = zx6(shamt);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate generator between decode and execute: one-cycle latency, output
// register backed by a one-entry skid so in_ready never depends on out_ready.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  imm_gen_stage_if.slave  bus
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end
  if (TAG_W < 1 || TAG_W > TAG_MAX_W) begin : g_bad_tag
    $error("imm_gen_stage: TAG_W out of range");
  end

  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .inst_i     (bus.in_inst),
    .imm_type_i (imm_type_e'(bus.in_imm_type)),
    .imm_o      (dec_imm),
    .illegal_o  (dec_illegal)
  );

  entry_t new_e;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_vld_q, out_vld_d;
  logic   skid_vld_q, skid_vld_d;
  logic   acc, drain;

  always_comb begin
    new_e                   = '0;
    new_e.imm[XLEN-1:0]     = dec_imm;
    new_e.tag[TAG_W-1:0]    = bus.in_tag;
    new_e.illegal           = dec_illegal;
  end

  assign acc   = bus.in_valid && !skid_vld_q;
  assign drain = out_vld_q && bus.out_ready;

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      // a same-cycle drain has already been seen downstream; nothing to undo
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || drain) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (acc) begin
        out_d     = new_e;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (acc) begin
      skid_d     = new_e;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign bus.in_ready    = !skid_vld_q;
  assign bus.out_valid   = out_vld_q;
  assign bus.out_imm     = out_q.imm[XLEN-1:0];
  assign bus.out_tag     = out_q.tag[TAG_W-1:0];
  assign bus.out_illegal = out_q.illegal;

  // padding bits of the wide entry format are intentionally left unread
  logic unused_pad;
  assign unused_pad = ^out_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Drives a 32-bit and a 64-bit stage in lockstep and compares both against a
// queue-based occupancy model with arithmetic immediate reference.
module tb_imm_gen_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32), .TAG_W(5)) b32 ();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(5)) b64 ();

  imm_gen_stage #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));
  imm_gen_stage #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  typ;
    logic [4:0]  tag;
  } txn_t;

  txn_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] typ,
                                          input int xlen);
    longint      sx, t;
    logic [63:0] r;
    sx = longint'($signed(inst));
    t  = sx >>> 31;
    case (typ)
      3'd0: r = sx >>> 20;
      3'd1: r = 64'((inst >> 15) & 32'd31);
      3'd2: begin t = sx >>> 25; r = (t << 5) | 64'((inst >> 7) & 32'd31); end
      3'd3: r = (t << 12) | 64'(((inst >> 7) & 32'd1) << 11)
                | 64'(((inst >> 25) & 32'd63) << 5) | 64'(((inst >> 8) & 32'd15) << 1);
      3'd4: r = sx & ~64'hFFF;
      3'd5: r = (t << 20) | 64'(((inst >> 12) & 32'd255) << 12)
                | 64'(((inst >> 20) & 32'd1) << 11) | 64'(((inst >> 21) & 32'd1023) << 1);
      3'd6: r = 64'((inst >> 20) & ((xlen == 64) ? 32'd63 : 32'd31));
      default: r = 64'd0;
    endcase
    if (xlen == 32) r = r & 64'hFFFF_FFFF;
    return r;
  endfunction

  task automatic check_state();
    chk("vld32", 64'(b32.out_valid), 64'(q.size() > 0));
    chk("vld64", 64'(b64.out_valid), 64'(q.size() > 0));
    chk("rdy32", 64'(b32.in_ready), 64'(q.size() < 2));
    chk("rdy64", 64'(b64.in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("imm32", 64'(b32.out_imm), ref_imm(q[0].inst, q[0].typ, 32));
      chk("imm64", b64.out_imm, ref_imm(q[0].inst, q[0].typ, 64));
      chk("tag32", 64'(b32.out_tag), 64'(q[0].tag));
      chk("tag64", 64'(b64.out_tag), 64'(q[0].tag));
      chk("ill32", 64'(b32.out_illegal), 64'(q[0].typ == 3'd7));
      chk("ill64", 64'(b64.out_illegal), 64'(q[0].typ == 3'd7));
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [2:0] typ,
                       input logic [4:0] tag, input logic ordy, input logic fl);
    b32.in_valid = v;  b32.in_inst = inst;  b32.in_imm_type = typ;  b32.in_tag = tag;
    b64.in_valid = v;  b64.in_inst = inst;  b64.in_imm_type = typ;  b64.in_tag = tag;
    b32.out_ready = ordy;
    b64.out_ready = ordy;
    flush = fl;
  endtask

  // called just after a falling edge; returns at the next falling edge
  task automatic step(input logic v, input logic [31:0] inst, input logic [2:0] typ,
                      input logic [4:0] tag, input logic ordy, input logic fl);
    int   sz;
    txn_t e;
    sz = q.size();
    drive(v, inst, typ, tag, ordy, fl);
    if (fl) q.delete();
    else begin
      if (sz > 0 && ordy) void'(q.pop_front());
      if (v && sz < 2) begin
        e.inst = inst; e.typ = typ; e.tag = tag;
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_vld32"}, 64'(b32.out_valid), 64'd0);
    chk({pfx, "_vld64"}, 64'(b64.out_valid), 64'd0);
    chk({pfx, "_rdy32"}, 64'(b32.in_ready), 64'd1);
    chk({pfx, "_imm32"}, 64'(b32.out_imm), 64'd0);
    chk({pfx, "_imm64"}, b64.out_imm, 64'd0);
    chk({pfx, "_tag32"}, 64'(b32.out_tag), 64'd0);
    chk({pfx, "_ill64"}, 64'(b64.out_illegal), 64'd0);
  endtask

  initial begin
    drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0);
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // directed encodings, downstream always ready
    step(1'b1, 32'hFFF00093, 3'd0, 5'd1, 1'b1, 1'b0);
    chk("t1_imm32", 64'(b32.out_imm), 64'hFFFF_FFFF);
    chk("t1_ill32", 64'(b32.out_illegal), 64'd0);
    step(1'b1, 32'hFE000EE3, 3'd3, 5'd2, 1'b1, 1'b0);
    chk("t2_b32", 64'(b32.out_imm), 64'hFFFF_FFFC);
    step(1'b1, 32'h000F8000, 3'd1, 5'd3, 1'b1, 1'b0);
    chk("t2_z32", 64'(b32.out_imm), 64'h0000_001F);
    step(1'b1, 32'h800000B7, 3'd4, 5'd4, 1'b1, 1'b0);
    chk("t3_u64", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
    step(1'b1, 32'h03F00000, 3'd6, 5'd5, 1'b1, 1'b0);
    chk("t3_sh64", b64.out_imm, 64'h3F);
    chk("t3_sh32", 64'(b32.out_imm), 64'h1F);
    step(1'b1, 32'hDEADBEEF, 3'd7, 5'd6, 1'b1, 1'b0);
    chk("t6_ill32", 64'(b32.out_illegal), 64'd1);
    chk("t6_imm32", 64'(b32.out_imm), 64'd0);
    step(1'b0, 32'd0, 3'd0, 5'd0, 1'b1, 1'b0);

    // backpressure: 1 and 2 taken, 3 stalls, then all drain in order
    step(1'b1, $urandom, 3'd0, 5'd1, 1'b0, 1'b0);
    step(1'b1, $urandom, 3'd2, 5'd2, 1'b0, 1'b0);
    chk("bp_rdy_low", 64'(b32.in_ready), 64'd0);
    chk("bp_hold1", 64'(b32.out_tag), 64'd1);
    step(1'b1, 32'h12345678, 3'd5, 5'd3, 1'b0, 1'b0);
    chk("bp_still1", 64'(b32.out_tag), 64'd1);
    step(1'b1, 32'h12345678, 3'd5, 5'd3, 1'b1, 1'b0);
    chk("bp_out2", 64'(b32.out_tag), 64'd2);
    step(1'b1, 32'h12345678, 3'd5, 5'd3, 1'b1, 1'b0);
    chk("bp_out3", 64'(b32.out_tag), 64'd3);
    step(1'b0, 32'd0, 3'd0, 5'd0, 1'b1, 1'b0);
    chk("bp_empty", 64'(b32.out_valid), 64'd0);

    // flush with both entries full, then flush swallowing a same-cycle accept
    step(1'b1, $urandom, 3'd0, 5'd4, 1'b0, 1'b0);
    step(1'b1, $urandom, 3'd0, 5'd5, 1'b0, 1'b0);
    step(1'b1, $urandom, 3'd0, 5'd6, 1'b0, 1'b1);
    chk("fl_vld", 64'(b32.out_valid), 64'd0);
    chk("fl_rdy", 64'(b32.in_ready), 64'd1);
    step(1'b1, $urandom, 3'd1, 5'd7, 1'b0, 1'b0);
    step(1'b1, $urandom, 3'd1, 5'd8, 1'b0, 1'b1);
    chk("fl_acc_drop", 64'(b64.out_valid), 64'd0);
    step(1'b0, 32'd0, 3'd0, 5'd0, 1'b1, 1'b0);
    chk("fl_no_ghost", 64'(b64.out_valid), 64'd0);

    // asynchronous reset while full
    step(1'b1, 32'hFFFFFFFF, 3'd4, 5'd9, 1'b0, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 3'd4, 5'd10, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'd0, 3'd0, 5'd0, 1'b1, 1'b0);
    chk("arst_noreplay", 64'(b32.out_valid), 64'd0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 24) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
